// File: rtl/lsu_dcache_if_pkg.sv
// lsu_dcache_if_pkg: access-size codes, LSU states and
// store/alignment helpers shared by the load/store path.
package lsu_dcache_if_pkg;

  localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
  localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
  localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  function automatic logic [2:0] sz_norm(
    input logic [2:0] sz
  );
    logic [2:0] r;
    r = ACCESS_SZ_WORD;
    if (sz == ACCESS_SZ_BYTE || sz == ACCESS_SZ_HALF)
      r = sz;
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] lo,
    input logic [2:0] sz
  );
    logic r;
    unique case (1'b1)
      sz == ACCESS_SZ_BYTE: r = 1'b0;
      sz == ACCESS_SZ_HALF: r = lo[0];
      default:              r = |lo;
    endcase
    return r;
  endfunction

  // dcache write lanes are most-significant-byte first
  function automatic logic [31:0] store_swap(
    input logic [31:0] d,
    input logic [2:0]  sz
  );
    logic [31:0] r;
    unique case (1'b1)
      sz == ACCESS_SZ_BYTE:
        r = {24'b0, d[7:0]};
      sz == ACCESS_SZ_HALF:
        r = {16'b0, d[7:0], d[15:8]};
      default:
        r = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the low byte/half of a dcache
// read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_dcache_if_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  sz,
  input  logic        zext,
  output logic [31:0] data
);

  logic sb;
  logic sh;

  assign sb = ~zext & rdata[7];
  assign sh = ~zext & rdata[15];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      sz == ACCESS_SZ_BYTE: data = {{24{sb}}, rdata[7:0]};
      sz == ACCESS_SZ_HALF: data = {{16{sh}}, rdata[15:0]};
      default:              data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dcache_if.sv
// lsu_dcache_if: single-outstanding load/store initiator
// between the MEM stage and the dcache port.
module lsu_dcache_if
  import lsu_dcache_if_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_sz,
  input  logic              req_unsigned,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dc_re,
  output logic [ADDR_W-1:0] dc_raddr,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_waddr,
  output logic [31:0]       dc_wdata,
  output logic [2:0]        dc_wsz,
  input  logic [31:0]       dc_rdata,
  input  logic              dc_hit
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  lsu_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     lat_sz;
  logic           lat_uns;
  logic           lat_we;
  logic [2:0]     sz_n;
  logic [31:0]    ld_data;

  assign sz_n      = sz_norm(req_sz);
  assign req_ready = rst_n && (state == ST_IDLE) && !flush;

  lsu_load_align u_align (
    .rdata (dc_rdata),
    .sz    (lat_sz),
    .zext  (lat_uns),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_sz     <= ACCESS_SZ_WORD;
      lat_uns    <= 1'b0;
      lat_we     <= 1'b0;
      dc_re      <= 1'b0;
      dc_we      <= 1'b0;
      dc_raddr   <= '0;
      dc_waddr   <= '0;
      dc_wdata   <= '0;
      dc_wsz     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      dc_re <= 1'b0;
      dc_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat_sz     <= sz_n;
            lat_uns    <= req_unsigned;
            lat_we     <= req_we;
            resp_rdata <= '0;
            if (misaligned(req_addr[1:0], sz_n)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state    <= ST_ISSUE;
              resp_err <= 1'b0;
              if (req_we) begin
                dc_we    <= 1'b1;
                dc_waddr <= req_addr;
                dc_wsz   <= sz_n;
                dc_wdata <= store_swap(req_wdata, sz_n);
              end else begin
                dc_re    <= 1'b1;
                dc_raddr <= req_addr;
              end
            end
          end
        end
        ST_ISSUE: begin
          cnt <= CNT_INIT;
          if (lat_we) begin
            state      <= flush ? ST_IDLE : ST_RESP;
            resp_valid <= !flush;
          end else begin
            state <= flush ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= !dc_hit;
              resp_rdata <= dc_hit ? ld_data : 32'h0;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= ST_IDLE;
        end
        ST_RESP: begin
          if (flush || resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_dcache_if.md
Name: lsu_dcache_if

Overview:
- Load/store initiator for the data cache: takes one memory request at a time from the MEM pipeline stage and drives the dcache read/write port.
- Checks alignment and swaps bytes on stores so that loads return the stored value unchanged.
- Waits the fixed dcache read latency, then byte/half-extracts and sign- or zero-extends the load data.
- Returns a single response to the pipeline through a valid/ready handshake.

Parameters:
- RD_LAT, 2, cycles from the cycle dc_re is high to the cycle dc_rdata/dc_hit are valid (minimum 1).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- req_sz  in  3  access size (BYTE/HALF/WORD code)
- req_unsigned  in  1  zero-extend the load result
- flush  in  1  cancel the in-flight request and drop any pending response
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline takes the response
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  misaligned access or dcache miss
- dc_re  out  1  dcache read strobe
- dc_raddr  out  ADDR_W  read address
- dc_we  out  1  dcache write strobe
- dc_waddr  out  ADDR_W  write address
- dc_wdata  out  32  byte-swapped write data
- dc_wsz  out  3  write size
- dc_rdata  in  32  read data, little-endian, byte at raddr in [7:0]
- dc_hit  in  1  read valid/in range

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=0 during reset. resp_valid, resp_err, dc_re, dc_we = 0. All address/data outputs = 0.
- All dc_* and resp_* outputs are registered.
- req_ready = (state==IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready (edge E0). Attributes are latched at E0.
- Misaligned request: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
  - No dcache strobe is issued.
  - Next state is RESP with resp_err=1 and resp_rdata=0.
- Aligned request: goes to ISSUE. For exactly one cycle (C1):
  - Load: dc_re=1, dc_raddr=addr.
  - Store: dc_we=1, dc_waddr=addr, dc_wsz=sz.
  - Store data swap: BYTE → {24'b0, d[7:0]}; HALF → {16'b0, d[7:0], d[15:8]}; WORD → {d[7:0], d[15:8], d[23:16], d[31:24]}.
- Store: ISSUE → RESP. resp_valid is high from C2 with resp_err=0 and resp_rdata=0.
- Load: ISSUE → WAIT. A counter loads RD_LAT-1 and decrements each WAIT cycle.
  - In cycle C1+RD_LAT (count==0), dc_rdata/dc_hit are sampled.
  - BYTE: extend rdata[7:0]. HALF: extend rdata[15:0]. WORD: rdata as is.
  - Sign-extend unless req_unsigned.
  - resp_err = !dc_hit. On a miss, resp_rdata=0.
  - Next state is RESP, so resp_valid is high from C1+RD_LAT+1.
- RESP: resp_valid holds with stable data until resp_valid && resp_ready, then IDLE. No new request is accepted in the same cycle as the response handshake.
- Flush:
  - In IDLE: blocks acceptance.
  - In ISSUE: the strobe already driven is not retracted; the FSM goes to DRAIN (stores go straight to IDLE).
  - In WAIT: go to DRAIN.
  - In RESP: resp_valid drops next cycle and the FSM goes to IDLE.
  - DRAIN: finishes the latency count, discards the data, returns to IDLE, and never asserts resp_valid.
- Unknown req_sz codes are treated as WORD.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP (3-bit encoding).

Decomposition:
- Shared package/defs: access size codes ACCESS_SZ_BYTE=3'd0, ACCESS_SZ_HALF=3'd1, ACCESS_SZ_WORD=3'd2; LSU state encodings.
- One natural sub-module, lsu_load_align: combinational extract/extend of dc_rdata by size and unsigned flag. It is reused by later load paths.

Test Plan:
- Store WORD 0x11223344 @0x100 → dc_we=1 for one cycle, dc_wdata=0x44332211, dc_wsz=WORD; resp_valid in C2, resp_err=0. Then load WORD @0x100 → resp_rdata=0x11223344 at C1+3.
- Store HALF 0x8001 @0x202, then signed load HALF @0x202 → 0xFFFF8001; unsigned → 0x00008001.
- Store BYTE 0x80 @0x3 (signed) → load BYTE returns 0xFFFFFF80; neighbouring bytes are unchanged.
- Load WORD @0x102 → no dc_re, resp_err=1, resp_rdata=0 the cycle after acceptance. Load @0x4000 with dc_hit=0 → resp_err=1.
- flush asserted during WAIT of a load → resp_valid never rises; req_ready returns to 1 after the remaining latency cycles.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and data stay stable, req_ready=0. Assert rst_n=0 mid-WAIT → all outputs go to 0 immediately and state is IDLE.
